curl_trit_loader: RTL

- Parametrised load-path engine that turns a memory stream (one trit per byte) into write transactions for a curl_transform core.
- Takes a show-ahead memory FIFO (e.g. a read-master user buffer) and packs trits into TRITS_PER_WORD-trit core words.
- Writes WORDS_PER_BLOCK words per block, zero-pads the final block and handshakes with the core between blocks.
- Generalises the fixed 128-bit/27-trit/9-word load path of the curl accelerator.

---
 rtl/curl_trit_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/curl_trit_loader.sv
// curl_trit_loader: packs a one-trit-per-byte memory stream into core words and
// loads them into a curl core block by block. Define CURL_TRIT_LOADER_CHECK_EN to scrub invalid trits.
module curl_trit_loader #(
  parameter int MEM_DATA_WIDTH  = 128,
  parameter int TRITS_PER_WORD  = 27,
  parameter int WORDS_PER_BLOCK = 9,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [LEN_WIDTH-1:0]          i_len,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  input  logic [MEM_DATA_WIDTH-1:0]     i_mem_data,
  input  logic                          i_mem_valid,
  output logic                          o_mem_ready,
  output logic [2*TRITS_PER_WORD-1:0]   o_curl_data,
  output logic [$clog2((WORDS_PER_BLOCK > 1) ? WORDS_PER_BLOCK : 2)-1:0] o_curl_addr,
  output logic                          o_curl_we,
  output logic                          o_curl_block_last,
  input  logic                          i_curl_ready
);

  localparam int BYTES  = MEM_DATA_WIDTH / 8;
  localparam int LANE_W = $clog2((BYTES > 1) ? BYTES : 2);
  localparam int TRIT_W = $clog2((TRITS_PER_WORD > 1) ? TRITS_PER_WORD : 2);
  localparam int ADDR_W = $clog2((WORDS_PER_BLOCK > 1) ? WORDS_PER_BLOCK : 2);
  localparam int WORD_W = 2 * TRITS_PER_WORD;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CORE,
    FILL,
    WRITE
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [TRIT_W-1:0]    trit_q, trit_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WORD_W-1:0]    pack_q, pack_d;
  logic [WORD_W-1:0]    out_q, out_d;
  logic                 done_q, done_d;
`ifdef CURL_TRIT_LOADER_CHECK_EN
  logic                 err_q, err_d;
`endif

  logic       have_trits;
  logic       last_lane;
  logic       take;
  logic [1:0] lane_trit;
  logic [1:0] trit_val;
  logic       mem_unused;

  // Only the low two bits of each byte lane carry a trit.
  assign mem_unused = ^i_mem_data;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    lane_d      = lane_q;
    trit_d      = trit_q;
    addr_d      = addr_q;
    pack_d      = pack_q;
    out_d       = out_q;
    done_d      = 1'b0;
    o_mem_ready = 1'b0;
    take        = 1'b0;
    trit_val    = 2'b00;
`ifdef CURL_TRIT_LOADER_CHECK_EN
    err_d       = err_q;
`endif
    lane_trit   = i_mem_data[{lane_q, 3'b000} +: 2];
    have_trits  = (rem_q != '0);
    // The head word is popped after its top lane or after the message's final trit.
    last_lane   = (lane_q == LANE_W'(BYTES - 1)) || (rem_q == LEN_WIDTH'(1));

    case (state_q)
      IDLE: begin
        if (i_start) begin
          rem_d   = i_len;
          lane_d  = '0;
          trit_d  = '0;
          addr_d  = '0;
`ifdef CURL_TRIT_LOADER_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = WAIT_CORE;
        end
      end
      WAIT_CORE: begin
        if (i_curl_ready) state_d = FILL;
      end
      FILL: begin
        if (have_trits) begin
          take = i_mem_valid;
          if (i_mem_valid) begin
            trit_val = lane_trit;
`ifdef CURL_TRIT_LOADER_CHECK_EN
            if (lane_trit == 2'b10) begin
              trit_val = 2'b00;
              err_d    = 1'b1;
            end
`endif
            rem_d       = rem_q - LEN_WIDTH'(1);
            lane_d      = last_lane ? '0 : lane_q + LANE_W'(1);
            o_mem_ready = last_lane;
          end
        end else begin
          take = 1'b1;
        end
        if (take) begin
          pack_d[{trit_q, 1'b0} +: 2] = trit_val;
          if (trit_q == TRIT_W'(TRITS_PER_WORD - 1)) begin
            trit_d  = '0;
            out_d   = pack_d;
            state_d = WRITE;
          end else begin
            trit_d = trit_q + TRIT_W'(1);
          end
        end
      end
      WRITE: begin
        if (addr_q == ADDR_W'(WORDS_PER_BLOCK - 1)) begin
          addr_d = '0;
          if (have_trits) begin
            state_d = WAIT_CORE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      lane_q  <= '0;
      trit_q  <= '0;
      addr_q  <= '0;
      pack_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
`ifdef CURL_TRIT_LOADER_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      trit_q  <= trit_d;
      addr_q  <= addr_d;
      pack_q  <= pack_d;
      out_q   <= out_d;
      done_q  <= done_d;
`ifdef CURL_TRIT_LOADER_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign o_busy            = (state_q != IDLE);
  assign o_done            = done_q;
  assign o_curl_we         = (state_q == WRITE);
  assign o_curl_block_last = (state_q == WRITE) && (addr_q == ADDR_W'(WORDS_PER_BLOCK - 1));
  assign o_curl_addr       = addr_q;
  assign o_curl_data       = out_q;
`ifdef CURL_TRIT_LOADER_CHECK_EN
  assign o_err             = err_q;
`else
  assign o_err             = 1'b0;
`endif

endmodule
